qspis_wb_arb: RTL and testbench
===============================

# qspis_wb_arb

Two-requester Wishbone arbiter with a bus-hang watchdog, placed between the QSPI-slave Wishbone master (requester 0) and a second internal host (requester 1) in front of the single downstream Wishbone slave port. It grants whole Wishbone cycles round-robin and routes ack, err and read data back to the owner. If no ack or err arrives within a programmable window, it terminates the access with an error, so a missing slave cannot stall the SPI host.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; SEL width is DW/8
- TMO_CYC, 255, strobe-to-ack timeout in sys_clk cycles; 0 disables the watchdog

Ports:
- sys_clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  requester 0 (QSPI bridge) control
- m0_adr_i  in  AW  requester 0 address
- m0_dat_i  in  DW  requester 0 write data
- m0_sel_i  in  DW/8  requester 0 byte enables
- m0_dat_o  out  DW  requester 0 read data
- m0_ack_o, m0_err_o  out  1 each  requester 0 termination
- m1_*  same set as m0_*  requester 1 (internal host)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  downstream control
- s_adr_o  out  AW  downstream address
- s_dat_o  out  DW  downstream write data
- s_sel_o  out  DW/8  downstream byte enables
- s_dat_i  in  DW  downstream read data
- s_ack_i, s_err_i  in  1 each  downstream termination
- gnt_o  out  1  current owner index, valid while busy_o
- busy_o  out  1  bus owned
- tmo_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- FSM states: IDLE, BUSY, TMO.
- IDLE:
  - request is mN_cyc_i.
  - Single request: grant it.
  - Both requesting: grant the one that is not last_gnt.
  - Transition to BUSY registers gnt and updates last_gnt.
  - Reset value of last_gnt is 1, so m0 wins the first tie.
- BUSY:
  - s_* outputs combinationally mirror the granted requester's cyc, stb, we, adr, dat and sel.
  - s_ack_i, s_err_i and s_dat_i route only to the granted requester.
  - The non-granted requester sees ack=0, err=0 and dat=0.
- Ownership lasts while the owner holds cyc, which covers back-to-back strobes (block transfers).
- Owner drops cyc: return to IDLE next cycle. A request then present from the other requester is granted at that edge, giving one dead cycle between owners.
- Watchdog:
  - Counter clears on ack, on err, or when stb is low.
  - Counter increments each BUSY cycle with s_stb_o=1 and no ack/err.
  - When the count reaches TMO_CYC, go to TMO.
- TMO (one cycle):
  - s_stb_o forced 0; s_cyc_o forced 0.
  - Owner sees err_o=1 and tmo_o=1.
  - Next state BUSY; ownership is retained until the owner drops cyc.
- A late s_ack_i/s_err_i arriving in TMO or IDLE is discarded.
- Outputs (s_cyc_o, s_stb_o, all ack/err, busy_o, tmo_o) are 0 in IDLE.
- s_adr_o, s_dat_o, s_sel_o and s_we_o are 0 outside BUSY.

## Timing
- Reset: state IDLE, gnt=0, last_gnt=1, counter=0, every output 0.
- Reset mid-transfer: abort immediately with no ack/err to either requester.
- Request to s_stb_o: 1 cycle, the IDLE→BUSY edge.
- s_ack_i to mN_ack_o: 0 cycles, combinational.
- Simultaneous ack and timeout expiry in the same cycle: ack wins, counter clears, no TMO.
- s_ack_i and s_err_i together: both forwarded. This is the slave's fault and is not filtered.
- Owner drops cyc in the same cycle as ack: the transfer completes, and the state is IDLE next cycle.
- Counter width: $clog2(TMO_CYC+1). The counter saturates and never wraps.

## Structure
- Package qspis_pkg holds:
  - arb_state_e {IDLE, BUSY, TMO}
  - the requester-index type
  - default TMO_CYC
- Sub-module qspis_wb_tmo: watchdog counter with inputs en, clr and limit, and output expire.
- Everything else is flat in qspis_wb_arb.

## Test plan
- Single requester: m0 write 0xDEADBEEF to 0x1000_0004, sel=0xF, slave acks after 3 cycles → s_stb_o one cycle after m0_cyc_i; m0_ack_o pulses; m1 sees no ack; busy_o falls the cycle after cyc drop.
- Tie from reset: m0 and m1 request together → m0 first (gnt_o=0). Then repeat the tie → m1 is granted, alternating thereafter.
- Block hold: m1 does 4 back-to-back reads returning 0x11,0x22,0x33,0x44 with m0 requesting throughout → m0 is not granted until m1 drops cyc; m1 gets all four data values.
- Timeout: TMO_CYC=8, slave never acks → at cycle 8 of stb, m0_err_o=1 and tmo_o=1 for one cycle with s_stb_o=0. A late ack is discarded.
- Ack at the expiry cycle: ack on exactly the 8th stall cycle → m0_ack_o=1, err and tmo stay 0.
- Reset asserted mid-BUSY → all outputs 0 in the same cycle; after release, m0 wins the first tie.

Source files
------------

// File: rtl/qspis_pkg.sv
// Shared types and defaults for the QSPI-slave Wishbone arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package qspis_pkg;

    // Arbiter FSM: free bus, owned bus, one-cycle watchdog termination.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TMO  = 2'd2
    } arb_state_e;

    // Requester index: 0 = QSPI bridge, 1 = internal host.
    typedef logic req_idx_t;

    // Default strobe-to-ack window in sys_clk cycles (0 disables the watchdog).
    localparam int TMO_CYC_DEFAULT = 255;

endpackage

// File: rtl/qspis_wb_tmo.sv
// Bus-hang watchdog: counts stalled strobe cycles and flags expiry at the limit.
// Latency: expire is combinational in the cycle the count would reach limit.
// Backpressure: none; clr always wins, counter saturates instead of wrapping.
//
// Ports: sys_clk/rst clock and async reset, en = stalled strobe cycle,
// clr = ack/err/no strobe, limit = window (0 disables), expire = window hit.
module qspis_wb_tmo #(
    parameter int CW = 8
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    output logic          expire
);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expire in the cycle whose increment would make the count equal limit;
    // a concurrent clr (ack/err) suppresses it so a last-moment ack wins.
    always_comb begin
        expire = en && !clr && (limit != '0) && (cnt >= (limit - 1'b1));
    end

endmodule

// File: rtl/qspis_wb_arb.sv
// Two-requester round-robin Wishbone arbiter with bus-hang watchdog.
// Latency: request to s_stb_o 1 cycle; s_ack_i/s_err_i/s_dat_i to owner 0 cycles.
// Backpressure: whole Wishbone cycles granted; loser waits while owner holds cyc.
//
// Ports: m0_* (QSPI bridge) and m1_* (internal host) Wishbone masters in,
// s_* single downstream slave, gnt_o owner index, busy_o bus owned,
// tmo_o one-cycle pulse when the watchdog terminates an access.
module qspis_wb_arb
    import qspis_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic            gnt_o,
    output logic            busy_o,
    output logic            tmo_o
);

    // A zero window would give a zero-width counter; keep one bit and let
    // the zero limit disable expiry instead.
    localparam int CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TMO_CYC);

    arb_state_e state;
    req_idx_t   gnt;
    req_idx_t   last_gnt;
    req_idx_t   nxt_gnt;

    logic            in_busy;
    logic            in_tmo;
    logic            own_cyc;
    logic            own_stb;
    logic            own_we;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [DW/8-1:0] own_sel;
    logic            wd_en;
    logic            wd_clr;
    logic            wd_expire;

    always_comb begin
        in_busy = (state == BUSY);
        in_tmo  = (state == TMO);

        own_cyc = gnt ? m1_cyc_i : m0_cyc_i;
        own_stb = gnt ? m1_stb_i : m0_stb_i;
        own_we  = gnt ? m1_we_i  : m0_we_i;
        own_adr = gnt ? m1_adr_i : m0_adr_i;
        own_dat = gnt ? m1_dat_i : m0_dat_i;
        own_sel = gnt ? m1_sel_i : m0_sel_i;

        // On a tie the requester that did not own the bus last goes first.
        if (m0_cyc_i && m1_cyc_i) begin
            nxt_gnt = ~last_gnt;
        end else begin
            nxt_gnt = m1_cyc_i;
        end

        // Downstream mirrors the owner only in BUSY; TMO drops cyc/stb so the
        // hung slave sees the access abandoned.
        s_cyc_o = in_busy & own_cyc;
        s_stb_o = in_busy & own_cyc & own_stb;
        s_we_o  = in_busy & own_we;
        s_adr_o = in_busy ? own_adr : '0;
        s_dat_o = in_busy ? own_dat : '0;
        s_sel_o = in_busy ? own_sel : '0;

        // Slave terminations count only in BUSY, so late ones in TMO/IDLE drop.
        m0_ack_o = in_busy & ~gnt & s_ack_i;
        m1_ack_o = in_busy &  gnt & s_ack_i;
        m0_err_o = ~gnt & ((in_busy & s_err_i) | in_tmo);
        m1_err_o =  gnt & ((in_busy & s_err_i) | in_tmo);
        m0_dat_o = (in_busy & ~gnt) ? s_dat_i : '0;
        m1_dat_o = (in_busy &  gnt) ? s_dat_i : '0;

        busy_o = in_busy | in_tmo;
        gnt_o  = busy_o & gnt;
        tmo_o  = in_tmo;

        wd_en  = s_stb_o & ~s_ack_i & ~s_err_i;
        wd_clr = ~s_stb_o | s_ack_i | s_err_i;
    end

    qspis_wb_tmo #(
        .CW (CW)
    ) u_tmo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .en      (wd_en),
        .clr     (wd_clr),
        .limit   (LIMIT),
        .expire  (wd_expire)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        state    <= BUSY;
                        gnt      <= nxt_gnt;
                        last_gnt <= nxt_gnt;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                    end else if (wd_expire) begin
                        state <= TMO;
                    end
                end
                TMO:     state <= BUSY;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspis_wb_arb.sv
// Directed bench for qspis_wb_arb (watchdog window shortened to 8 cycles).
// Latency: n/a.
// Backpressure: bench plays both masters and the slave.
module tb_qspis_wb_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [3:0]    m0_sel_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [3:0]    m1_sel_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [3:0]    s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i;
    logic          gnt_o, busy_o, tmo_o;

    int cmp_cnt = 0;
    int err_cnt = 0;

    wire [141:0] all_out = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
                            m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
                            gnt_o, busy_o, tmo_o};

    always #5 sys_clk = ~sys_clk;

    qspis_wb_arb #(.AW(AW), .DW(DW), .TMO_CYC(8)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .tmo_o(tmo_o)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m0_cyc_i = 1; s_ack_i = 1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        cmp_cnt++;
        if (all_out !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        step();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_tie();
        logic exp_gnt;
        for (int i = 0; i < 3; i++) begin
            exp_gnt = (i % 2 == 1);
            step();
            m0_cyc_i = 1; m1_cyc_i = 1;
            step();
            @(negedge sys_clk);
            cmp_cnt++;
            if ({busy_o, gnt_o} !== {1'b1, exp_gnt}) begin
                err_cnt++;
                $display("FAIL tie_gnt[%0d]: got busy/gnt %b%b want 1%b", i, busy_o, gnt_o, exp_gnt);
            end
            step();
            m0_cyc_i = 0; m1_cyc_i = 0;
            step();
        end
    endtask

    task automatic test_single();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        m0_adr_i = 32'h1000_0004; m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'hF;
        @(negedge sys_clk);
        cmp_cnt++;
        if (s_stb_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_stb_early: got %b want 0", s_stb_o);
        end
        step();
        @(negedge sys_clk);
        cmp_cnt++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, gnt_o, m0_ack_o}
            !== {3'b111, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL single_mirror: got cyc/stb/we %b%b%b adr %h dat %h sel %h gnt %b ack %b want 111 10000004 deadbeef f 0 0",
                     s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, gnt_o, m0_ack_o);
        end
        step();
        step();
        s_ack_i = 1;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({m0_ack_o, m0_err_o, m1_ack_o} !== 3'b100) begin
            err_cnt++;
            $display("FAIL single_ack_route: got m0ack/m0err/m1ack %b%b%b want 100", m0_ack_o, m0_err_o, m1_ack_o);
        end
        step();
        s_ack_i = 0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({busy_o, s_cyc_o, m0_ack_o} !== 3'b100) begin
            err_cnt++;
            $display("FAIL single_drop_cycle: got busy/cyc/ack %b%b%b want 100", busy_o, s_cyc_o, m0_ack_o);
        end
        step();
        @(negedge sys_clk);
        cmp_cnt++;
        if (busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_busy_fall: got %b want 0", busy_o);
        end
    endtask

    task automatic test_block_hold();
        logic [31:0] rd [4];
        rd = '{32'h11, 32'h22, 32'h33, 32'h44};
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_2000;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_3000;
        step();
        for (int k = 0; k < 4; k++) begin
            s_ack_i = 1;
            s_dat_i = rd[k];
            @(negedge sys_clk);
            cmp_cnt++;
            if ({gnt_o, m1_ack_o, m1_dat_o, m0_ack_o, m0_dat_o} !== {2'b11, rd[k], 1'b0, 32'h0}) begin
                err_cnt++;
                $display("FAIL block_read[%0d]: got gnt %b m1ack %b m1dat %h m0ack %b m0dat %h want 1 1 %h 0 0",
                         k, gnt_o, m1_ack_o, m1_dat_o, m0_ack_o, m0_dat_o, rd[k]);
            end
            if (k < 3) step();
        end
        step();
        s_ack_i = 0; s_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({busy_o, gnt_o} !== 2'b11) begin
            err_cnt++;
            $display("FAIL block_hold_owner: got busy/gnt %b%b want 11", busy_o, gnt_o);
        end
        step();
        @(negedge sys_clk);
        cmp_cnt++;
        if (busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL block_dead_cycle: got busy %b want 0", busy_o);
        end
        step();
        @(negedge sys_clk);
        cmp_cnt++;
        if ({busy_o, gnt_o, s_adr_o} !== {2'b10, 32'h0000_2000}) begin
            err_cnt++;
            $display("FAIL block_handover: got busy/gnt %b%b adr %h want 10 00002000", busy_o, gnt_o, s_adr_o);
        end
        step();
        m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_4000;
        step();
        for (int s = 1; s <= 8; s++) begin
            @(negedge sys_clk);
            cmp_cnt++;
            if ({s_stb_o, m0_err_o, tmo_o} !== 3'b100) begin
                err_cnt++;
                $display("FAIL tmo_stall[%0d]: got stb/err/tmo %b%b%b want 100", s, s_stb_o, m0_err_o, tmo_o);
            end
            step();
        end
        s_ack_i = 1;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({m0_err_o, tmo_o, s_stb_o, s_cyc_o, m0_ack_o, busy_o, m1_err_o} !== 7'b1100010) begin
            err_cnt++;
            $display("FAIL tmo_expire: got err/tmo/stb/cyc/ack/busy/m1err %b%b%b%b%b%b%b want 1100010",
                     m0_err_o, tmo_o, s_stb_o, s_cyc_o, m0_ack_o, busy_o, m1_err_o);
        end
        step();
        s_ack_i = 0;
        m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({busy_o, tmo_o, m0_err_o} !== 3'b100) begin
            err_cnt++;
            $display("FAIL tmo_after: got busy/tmo/err %b%b%b want 100", busy_o, tmo_o, m0_err_o);
        end
        step();
        s_ack_i = 1;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({busy_o, m0_ack_o, m1_ack_o} !== 3'b000) begin
            err_cnt++;
            $display("FAIL late_ack_idle: got busy/m0ack/m1ack %b%b%b want 000", busy_o, m0_ack_o, m1_ack_o);
        end
        step();
        s_ack_i = 0;
    endtask

    task automatic test_ack_at_expiry();
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        for (int s = 1; s < 8; s++) step();
        s_ack_i = 1;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({m0_ack_o, m0_err_o, tmo_o} !== 3'b100) begin
            err_cnt++;
            $display("FAIL ack_expiry: got ack/err/tmo %b%b%b want 100", m0_ack_o, m0_err_o, tmo_o);
        end
        step();
        s_ack_i = 0;
        @(negedge sys_clk);
        cmp_cnt++;
        if ({busy_o, s_stb_o, tmo_o, m0_err_o} !== 4'b1100) begin
            err_cnt++;
            $display("FAIL ack_expiry_next: got busy/stb/tmo/err %b%b%b%b want 1100", busy_o, s_stb_o, tmo_o, m0_err_o);
        end
        step();
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h0000_5000; m0_sel_i = 4'h3;
        step();
        s_ack_i = 1;
        @(negedge sys_clk);
        cmp_cnt++;
        if (m0_ack_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_pre_ack: got %b want 1", m0_ack_o);
        end
        #2;
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if (all_out !== '0) begin
            err_cnt++;
            $display("FAIL rstmid_outputs: got %h want 0", all_out);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        step();
        m0_cyc_i = 1; m1_cyc_i = 1;
        step();
        @(negedge sys_clk);
        cmp_cnt++;
        if ({busy_o, gnt_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL rstmid_first_tie: got busy/gnt %b%b want 10", busy_o, gnt_o);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish within bound");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_block_hold();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
